param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//   Parametrised single-clock FIFO that replaces the fixed 2^10 x 8 async SRAM
//   and its external read/write select. Internal memory has DATA_W width and
//   2^ADDR_W depth. The block owns the write/read pointers and the full/empty
//   and almost-full/almost-empty flags. It sits between a producer and a
//   consumer stage in the datapath.
// PARAMETERS
//   DATA_W     8    word width, bits
//   ADDR_W     10   address width; DEPTH = 2**ADDR_W words
//   AF_THRESH  1020 almost_full asserted when count >= AF_THRESH
//   AE_THRESH  4    almost_empty asserted when count <= AE_THRESH
// PORTS
//   clk           in   1         rising-edge clock
//   rst           in   1         asynchronous reset, active-high
//   wr_en         in   1         write request
//   wr_data       in   DATA_W    write word
//   rd_en         in   1         read request
//   rd_data       out  DATA_W    registered read word
//   rd_valid      out  1         rd_data updated this cycle (1-cycle pulse)
//   full          out  1         count == DEPTH
//   empty         out  1         count == 0
//   almost_full   out  1         count >= AF_THRESH
//   almost_empty  out  1         count <= AE_THRESH
//   count         out  ADDR_W+1  words stored, 0..DEPTH
//   overflow      out  1         sticky; present only with FIFO_ERR_FLAGS_EN
//   underflow     out  1         sticky; present only with FIFO_ERR_FLAGS_EN
// BEHAVIOUR
//   - Reset: rst=1 acts immediately, with no clock needed.
//       wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1,
//       almost_full=0, rd_data=0, rd_valid=0, overflow=underflow=0.
//   - Memory contents are not reset. Reset mid-stream discards all stored words.
//   - Pointers are ADDR_W+1 bits. Low ADDR_W bits index memory; the MSB is a wrap bit.
//       full  = (ptr MSBs differ, low bits equal)
//       empty = (pointers equal)
//   - Accept rules use the flags as registered before the edge:
//       write accepted iff wr_en && !full
//       read  accepted iff rd_en && !empty
//   - Accepted write: mem[wr_ptr] <= wr_data; wr_ptr++ (wraps DEPTH-1 -> 0).
//   - Accepted read: rd_data <= mem[rd_ptr] at that edge; rd_valid=1 for one cycle;
//     rd_ptr++. Latency is 1 clock from rd_en sampled to rd_data valid.
//   - Rejected or absent read: rd_data holds its value and rd_valid=0.
//   - Simultaneous accepted read+write: count is unchanged and both pointers advance.
//   - Empty + wr_en + rd_en: only the write is accepted; count becomes 1.
//     There is no fall-through.
//   - Full + wr_en + rd_en: only the read is accepted; count becomes DEPTH-1.
//   - count, full, empty, almost_* are registered and valid in the cycle after
//     the edge that changed occupancy.
//   - Ignored requests (write when full, read when empty) leave all state
//     unchanged. Data is never corrupted.
// CONFIGURATION
//   FIFO_ERR_FLAGS_EN defined:
//     overflow  sets on wr_en && full.
//     underflow sets on rd_en && empty.
//     Both stay high until rst.
//   FIFO_ERR_FLAGS_EN undefined:
//     overflow/underflow ports and logic are absent; ignored requests are silent.
// TESTING (DATA_W=8, ADDR_W=4, AF_THRESH=14, AE_THRESH=2, DEPTH=16)
//   1. Reset: assert rst with no clock -> empty=1, count=0, rd_valid=0, full=0.
//      After release, idle -> outputs stable.
//   2. Fill: write 0x01..0x10 -> full=1, count=16, almost_full=1 from count=14.
//      Then write 0xFF -> ignored; overflow=1 if EN.
//   3. Drain: read 16 times -> rd_data 0x01..0x10 in order, each one cycle after
//      rd_en with rd_valid=1. Then empty=1. A 17th read -> rd_valid=0,
//      rd_data holds 0x10, underflow=1 if EN.
//   4. Concurrent: at count=5 hold wr_en=rd_en=1 for 40 cycles with an
//      incrementing pattern -> count stays 5, both pointers wrap twice,
//      read order matches write order.
//   5. Edge concurrency:
//      empty + wr+rd -> count=1, rd_valid=0.
//      full + wr+rd  -> count=15, the written word is not stored.
//   6. Mid-stream reset: at count=7 pulse rst between clock edges -> empty=1,
//      count=0 immediately. A subsequent write 0xA5 then read -> 0xA5.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: inferred memory, registered read port, wrap-bit pointers and registered level flags.
// Optional sticky overflow/underflow outputs are built when FIFO_ERR_FLAGS_EN is defined.
module param_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int AF_THRESH = 1020,
    parameter int AE_THRESH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [ADDR_W:0]   o_count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow
`endif
);

    localparam int             DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL = AE_THRESH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_wr_ptr_next;
    logic [ADDR_W:0]   w_rd_ptr_next;
    logic [ADDR_W:0]   w_count_next;
    logic              w_full_next;
    logic              w_empty_next;

    // Acceptance uses the registered flags, so a full FIFO never takes a write
    // even when a read frees a slot on the same edge (and vice versa for empty).
    assign w_wr_acc      = i_wr_en && !r_full;
    assign w_rd_acc      = i_rd_en && !r_empty;
    assign w_wr_ptr_next = r_wr_ptr + (ADDR_W + 1)'(w_wr_acc);
    assign w_rd_ptr_next = r_rd_ptr + (ADDR_W + 1)'(w_rd_acc);
    assign w_count_next  = w_wr_ptr_next - w_rd_ptr_next;
    assign w_full_next   = (w_wr_ptr_next[ADDR_W] != w_rd_ptr_next[ADDR_W]) &&
                           (w_wr_ptr_next[ADDR_W-1:0] == w_rd_ptr_next[ADDR_W-1:0]);
    assign w_empty_next  = (w_wr_ptr_next == w_rd_ptr_next);

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_full         <= w_full_next;
            r_empty        <= w_empty_next;
            r_almost_full  <= (w_count_next >= AF_LVL);
            r_almost_empty <= (w_count_next <= AE_LVL);
            r_rd_valid     <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (i_rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`endif

    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised bench for param_sync_fifo (DEPTH=16) against a queue-based model of the FIFO.
// Build with FIFO_ERR_FLAGS_EN defined to also check the sticky error flags.
module tb_param_sync_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF_TH  = 14;
    localparam int AE_TH  = 2;

    logic              clk = 1'b0;
    bit                clk_run = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: stored words, last read word, valid pulse, sticky errors
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd_data;
    bit                m_valid;
    bit                m_ovf;
    bit                m_unf;

    param_sync_fifo #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AF_THRESH(AF_TH),
        .AE_THRESH(AE_TH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_full        (full),
        .o_empty       (empty),
        .o_almost_full (almost_full),
        .o_almost_empty(almost_empty),
        .o_count       (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .o_overflow    (overflow),
        .o_underflow   (underflow)
`endif
    );

    always #5 if (clk_run) clk = ~clk;

    // {full, empty, almost_full, almost_empty, count} as the model sees it
    function automatic logic [ADDR_W+4:0] exp_status();
        int n;
        n = q.size();
        return {n == DEPTH, n == 0, n >= AF_TH, n <= AE_TH, 5'(n)};
    endfunction

    function automatic logic [ADDR_W+4:0] dut_status();
        return {full, empty, almost_full, almost_empty, count};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_rd_data = '0;
        m_valid   = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endfunction

    // Drives one clock of requests, advances the model, and leaves time at posedge+1
    task automatic drive_cycle(input bit wr, input logic [DATA_W-1:0] d, input bit rd);
        bit was_full;
        bit was_empty;
        wr_en     = wr;
        wr_data   = d;
        rd_en     = rd;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        m_valid = 1'b0;
        if (rd && !was_empty) begin
            m_rd_data = q.pop_front();
            m_valid   = 1'b1;
        end
        if (wr && !was_full) q.push_back(d);
        if (wr && was_full) m_ovf = 1'b1;
        if (rd && was_empty) m_unf = 1'b1;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("txn t=%0t wr=%0b rd=%0b d=%02h -> valid=%0b rd_data=%02h count=%0d",
                 $time, wr, rd, d, rd_valid, rd_data, count);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_status() !== exp_status()) begin
            bad++;
            $display("FAIL reset_async_status: got %b want %b", dut_status(), exp_status());
        end
        total++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset_async_read: got valid=%b data=%h want valid=0 data=00", rd_valid, rd_data);
        end
        clk_run = 1'b1;
        #9 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b0);
            total++;
            if (dut_status() !== exp_status() || rd_valid !== 1'b0 || rd_data !== '0) begin
                bad++;
                $display("FAIL reset_idle: got st=%b v=%b d=%h want st=%b v=0 d=00",
                         dut_status(), rd_valid, rd_data, exp_status());
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0);
            total++;
            if (dut_status() !== exp_status() || rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL fill_status[%0d]: got st=%b v=%b want st=%b v=0",
                         i, dut_status(), rd_valid, exp_status());
            end
        end
        drive_cycle(1'b1, 8'hFF, 1'b0);
        total++;
        if (dut_status() !== exp_status() || count !== 5'd16 || full !== 1'b1) begin
            bad++;
            $display("FAIL fill_overrun: got st=%b want st=%b", dut_status(), exp_status());
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== m_ovf || underflow !== m_unf) begin
            bad++;
            $display("FAIL overflow_flag: got ovf=%b unf=%b want ovf=%b unf=%b",
                     overflow, underflow, m_ovf, m_unf);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data || rd_data !== 8'(i)) begin
                bad++;
                $display("FAIL drain_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, m_rd_data);
            end
            total++;
            if (dut_status() !== exp_status()) begin
                bad++;
                $display("FAIL drain_status[%0d]: got %b want %b", i, dut_status(), exp_status());
            end
        end
        drive_cycle(1'b0, '0, 1'b1);
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h10 || empty !== 1'b1) begin
            bad++;
            $display("FAIL drain_underrun: got v=%b d=%h e=%b want v=0 d=10 e=1", rd_valid, rd_data, empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== m_ovf || underflow !== m_unf) begin
            bad++;
            $display("FAIL underflow_flag: got ovf=%b unf=%b want ovf=%b unf=%b",
                     overflow, underflow, m_ovf, m_unf);
        end
`endif
    endtask

    task automatic test_concurrent();
        logic [DATA_W-1:0] pat;
        pat = 8'(DATA_W'($urandom));
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, pat, 1'b0);
            pat++;
        end
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, pat, 1'b1);
            pat++;
            total++;
            if (count !== 5'd5 || dut_status() !== exp_status()) begin
                bad++;
                $display("FAIL concurrent_count[%0d]: got st=%b want st=%b", i, dut_status(), exp_status());
            end
            total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                bad++;
                $display("FAIL concurrent_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, m_rd_data);
            end
        end
        while (q.size() > 0) begin
            drive_cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_data !== m_rd_data || rd_valid !== 1'b1) begin
                bad++;
                $display("FAIL concurrent_tail: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, m_rd_data);
            end
        end
    endtask

    task automatic test_edge_concurrency();
        drive_cycle(1'b1, 8'h3C, 1'b1);
        total++;
        if (count !== 5'd1 || rd_valid !== 1'b0 || dut_status() !== exp_status()) begin
            bad++;
            $display("FAIL edge_empty_wr_rd: got cnt=%0d v=%b want cnt=1 v=0", count, rd_valid);
        end
        while (q.size() < DEPTH) drive_cycle(1'b1, 8'($urandom_range(0, 8'hED)), 1'b0);
        drive_cycle(1'b1, 8'hEE, 1'b1);
        total++;
        if (count !== 5'd15 || rd_valid !== 1'b1 || rd_data !== m_rd_data || dut_status() !== exp_status()) begin
            bad++;
            $display("FAIL edge_full_wr_rd: got cnt=%0d v=%b d=%h want cnt=15 v=1 d=%h",
                     count, rd_valid, rd_data, m_rd_data);
        end
        while (q.size() > 0) begin
            drive_cycle(1'b0, '0, 1'b1);
            total++;
            if (rd_data !== m_rd_data || rd_data === 8'hEE) begin
                bad++;
                $display("FAIL edge_full_drain: got d=%h want d=%h (never EE)", rd_data, m_rd_data);
            end
        end
    endtask

    task automatic test_random();
        int bias;
        bit wr;
        bit rd;
        for (int i = 0; i < 300; i++) begin
            bias = (i < 150) ? 70 : 30;
            wr = ($urandom_range(0, 99) < bias);
            rd = ($urandom_range(0, 99) < (100 - bias));
            drive_cycle(wr, 8'($urandom), rd);
            total++;
            if (dut_status() !== exp_status()) begin
                bad++;
                $display("FAIL random_status[%0d]: got %b want %b", i, dut_status(), exp_status());
            end
            total++;
            if (rd_valid !== m_valid || rd_data !== m_rd_data) begin
                bad++;
                $display("FAIL random_read[%0d]: got v=%b d=%h want v=%b d=%h",
                         i, rd_valid, rd_data, m_valid, m_rd_data);
            end
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== m_ovf || underflow !== m_unf) begin
            bad++;
            $display("FAIL random_err_flags: got ovf=%b unf=%b want ovf=%b unf=%b",
                     overflow, underflow, m_ovf, m_unf);
        end
`endif
    endtask

    task automatic test_midstream_reset();
        while (q.size() > 7) drive_cycle(1'b0, '0, 1'b1);
        while (q.size() < 7) drive_cycle(1'b1, 8'($urandom), 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (dut_status() !== exp_status() || rd_valid !== 1'b0 || rd_data !== '0) begin
            bad++;
            $display("FAIL midreset_async: got st=%b v=%b d=%h want st=%b v=0 d=00",
                     dut_status(), rd_valid, rd_data, exp_status());
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL midreset_err_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
        end
`endif
        #1 rst = 1'b0;
        drive_cycle(1'b1, 8'hA5, 1'b0);
        total++;
        if (count !== 5'd1 || dut_status() !== exp_status()) begin
            bad++;
            $display("FAIL midreset_write: got st=%b want st=%b", dut_status(), exp_status());
        end
        drive_cycle(1'b0, '0, 1'b1);
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || empty !== 1'b1) begin
            bad++;
            $display("FAIL midreset_read: got v=%b d=%h e=%b want v=1 d=a5 e=1", rd_valid, rd_data, empty);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_concurrent();
        test_edge_concurrency();
        test_random();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
